wb_arbiter: RTL

- Write-back arbiter that drives the single general-register-file write port (`en`/`waddr`/`wdata`).
- Merges two result sources:
  - Source A: the in-order pipeline result. Never stalls, highest priority.
  - Source B: the multi-cycle result (mul/div, late loads). Valid/ready handshake, buffered in a small FIFO.
- Exports a per-register pending mask so decode can stall on queued writes.

---
 rtl/wb_arbiter_if.sv | 39 +++
 rtl/wb_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's bus signals.
//   a_*      : source A (in-order pipeline) write request, no back-pressure
//   b_*      : source B (multi-cycle results) write request, valid/ready
//   wb_*     : registered general-register-file write port
//   pending  : per-register mask of queued or in-flight source-B writes
//   b_count  : occupied source-B FIFO entries (killed entries included)
// Modport slave is taken by the arbiter, master by whoever drives it.
interface wb_arbiter_if #(
   parameter int unsigned PTR_W = 2
);
   logic             a_valid;
   logic [4:0]       a_waddr;
   logic [31:0]      a_wdata;
   logic             b_valid;
   logic             b_ready;
   logic [4:0]       b_waddr;
   logic [31:0]      b_wdata;
   logic             wb_en;
   logic [4:0]       wb_waddr;
   logic [31:0]      wb_wdata;
   logic [31:0]      pending;
   logic [PTR_W:0]   b_count;

   modport slave (
      input  a_valid, a_waddr, a_wdata,
      input  b_valid, b_waddr, b_wdata,
      output b_ready,
      output wb_en, wb_waddr, wb_wdata,
      output pending, b_count
   );

   modport master (
      output a_valid, a_waddr, a_wdata,
      output b_valid, b_waddr, b_wdata,
      input  b_ready,
      input  wb_en, wb_waddr, wb_wdata,
      input  pending, b_count
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// Source A (pipeline) always wins; source B (mul/div, late loads) is buffered
// in a DEPTH-entry FIFO and drains when A is idle. A younger A write to a
// register kills any queued B entries for the same register.
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   bus     : wb_arbiter_if.slave (source A/B requests, wb_* port, pending,
//             b_count)
// Optional feature macro: WB_BYPASS_EN -- when defined, a B write arriving at
// an empty FIFO with no A write that cycle loads the output register directly
// (1-cycle latency) instead of being enqueued.
module wb_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic         clk,
   input  logic         resetn,
   wb_arbiter_if.slave  bus
);

   localparam int unsigned AW   = 5;
   localparam int unsigned DW   = 32;
   localparam int unsigned CW   = PTR_W + 1;
   localparam int unsigned NREG = 32;

   typedef struct packed {
      logic          valid;
      logic          kill;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
   } entry_t;

   entry_t           fifo_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CW-1:0]    count_q;

   logic             wb_en_q;
   logic [AW-1:0]    wb_waddr_q;
   logic [DW-1:0]    wb_wdata_q;
   logic             wb_from_b_q;

   logic             b_ready_c;
   logic             a_wr_c;
   logic             b_wr_c;
   logic             pop_c;
   logic             pop_wr_c;
   logic             push_c;
   logic             bypass_c;
   entry_t           head_c;
   entry_t           new_ent_c;
   logic [NREG-1:0]  pending_c;

   // Handshake, priority and FIFO control decode
   always_comb begin
      b_ready_c = (count_q != CW'(DEPTH));
      a_wr_c    = bus.a_valid & (bus.a_waddr != '0);
      // Register-0 B writes complete the handshake but are otherwise dropped
      b_wr_c    = bus.b_valid & b_ready_c & (bus.b_waddr != '0);
      head_c    = fifo_q[rd_ptr_q];
      pop_wr_c  = ~a_wr_c & head_c.valid & ~head_c.kill;
      // A killed head leaves regardless of A; a live head only when A is idle
      pop_c     = head_c.valid & (head_c.kill | pop_wr_c);
`ifdef WB_BYPASS_EN
      bypass_c  = b_wr_c & ~a_wr_c & (count_q == '0);
`else
      bypass_c  = 1'b0;
`endif
      push_c    = b_wr_c & ~bypass_c;
      // An A write in the same cycle is program-younger than the B result
      new_ent_c.valid = 1'b1;
      new_ent_c.kill  = a_wr_c & (bus.a_waddr == bus.b_waddr);
      new_ent_c.waddr = bus.b_waddr;
      new_ent_c.wdata = bus.b_wdata;
   end

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (a_wr_c && fifo_q[i].valid && (fifo_q[i].waddr == bus.a_waddr)) begin
               fifo_q[i].kill <= 1'b1;
            end
         end
         if (pop_c) begin
            fifo_q[rd_ptr_q].valid <= 1'b0;
            rd_ptr_q               <= rd_ptr_q + PTR_W'(1);
         end
         if (push_c) begin
            fifo_q[wr_ptr_q] <= new_ent_c;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CW'(push_c) - CW'(pop_c);
      end
   end

   // Output register: A, then FIFO head, then (optionally) direct B
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wb_en_q     <= 1'b0;
         wb_waddr_q  <= '0;
         wb_wdata_q  <= '0;
         wb_from_b_q <= 1'b0;
      end else if (a_wr_c) begin
         wb_en_q     <= 1'b1;
         wb_waddr_q  <= bus.a_waddr;
         wb_wdata_q  <= bus.a_wdata;
         wb_from_b_q <= 1'b0;
      end else if (pop_wr_c) begin
         wb_en_q     <= 1'b1;
         wb_waddr_q  <= head_c.waddr;
         wb_wdata_q  <= head_c.wdata;
         wb_from_b_q <= 1'b1;
      end else if (bypass_c) begin
         wb_en_q     <= 1'b1;
         wb_waddr_q  <= bus.b_waddr;
         wb_wdata_q  <= bus.b_wdata;
         wb_from_b_q <= 1'b1;
      end else begin
         wb_en_q     <= 1'b0;
         wb_from_b_q <= 1'b0;
      end
   end

   // Pending mask from registered state only
   always_comb begin
      pending_c = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (fifo_q[i].valid && !fifo_q[i].kill) begin
            pending_c[fifo_q[i].waddr] = 1'b1;
         end
      end
      if (wb_en_q && wb_from_b_q) begin
         pending_c[wb_waddr_q] = 1'b1;
      end
      pending_c[0] = 1'b0;
   end

   assign bus.b_ready  = b_ready_c;
   assign bus.wb_en    = wb_en_q;
   assign bus.wb_waddr = wb_waddr_q;
   assign bus.wb_wdata = wb_wdata_q;
   assign bus.pending  = pending_c;
   assign bus.b_count  = count_q;

endmodule
